// File: rtl/x_uart_cmd_ctrl_if.sv
// Byte-level handshake bundle between the UART command sequencer, the UART
// receiver/transmitter and the register bank strobe port.
interface x_uart_cmd_ctrl_if;
    // receiver byte strobe
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    // register bank write strobe
    logic       o_wr_valid;
    logic [3:0] o_wr_addr;
    logic [7:0] o_wr_data;
    // register bank read strobe and returned data
    logic       o_rd_valid;
    logic [3:0] o_rd_addr;
    logic [7:0] i_rd_data;
    // transmitter byte handshake
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       i_tx_ready;
    // protocol error reporting
    logic       o_err;
    logic [7:0] o_err_cnt;

    // Sequencer side
    modport master (
        input  i_rx_valid, i_rx_data, i_rd_data, i_tx_ready,
        output o_wr_valid, o_wr_addr, o_wr_data,
        output o_rd_valid, o_rd_addr,
        output o_tx_valid, o_tx_data,
        output o_err, o_err_cnt
    );

    // Receiver / register bank / transmitter side
    modport slave (
        output i_rx_valid, i_rx_data, i_rd_data, i_tx_ready,
        input  o_wr_valid, o_wr_addr, o_wr_data,
        input  o_rd_valid, o_rd_addr,
        input  o_tx_valid, o_tx_data,
        input  o_err, o_err_cnt
    );
endinterface

// File: rtl/x_uart_cmd_ctrl.sv
// UART command sequencer: turns received opcode/data bytes into register bank
// write and read strobes, returns read data over the TX byte handshake, aborts
// a write whose data byte is too late, and counts protocol errors.
//
// Opcode byte: [7:6] = 2'b10 write, 2'b01 read, anything else is invalid;
//              [5:4] don't care; [3:0] register address.
module x_uart_cmd_ctrl #(
    parameter int p_timeout = 1200
) (
    input  logic              i_clk,
    input  logic              i_rst,
    x_uart_cmd_ctrl_if.master bus
);

    localparam int c_timer_w = $clog2(p_timeout + 1);
    localparam logic [c_timer_w-1:0] c_timeout = c_timer_w'(p_timeout);
    localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WRITE,
        READ,
        CAPT,
        SEND
    } state_t;

    state_t                 state_reg;
    logic [c_timer_w-1:0]   timer_reg;
    logic [c_timer_w-1:0]   timer_next;
    logic                   timer_expired;
    logic [3:0]             cmd_addr_reg;

    logic                   wr_valid_reg;
    logic [3:0]             wr_addr_reg;
    logic [7:0]             wr_data_reg;
    logic                   rd_valid_reg;
    logic [3:0]             rd_addr_reg;
    logic                   tx_valid_reg;
    logic [7:0]             tx_data_reg;
    logic                   err_reg;
    logic [7:0]             err_cnt_reg;

    logic                   op_is_wr;
    logic                   op_is_rd;
    logic                   err_next;

    assign op_is_wr = (bus.i_rx_data[7:6] == 2'b10);
    assign op_is_rd = (bus.i_rx_data[7:6] == 2'b01);

    // Inter-byte timer: expiry is the cycle in which the count would reach
    // p_timeout, so a data byte landing in that same cycle is still accepted.
    always_comb begin
        timer_next    = timer_reg + c_timer_one;
        timer_expired = (timer_next == c_timeout);
    end

    // Error sources: invalid opcode, data-byte timeout, or a byte that lands
    // while a command is still being executed.
    always_comb begin
        err_next = 1'b0;
        case (state_reg)
            IDLE:    err_next = bus.i_rx_valid && !op_is_wr && !op_is_rd;
            WDATA:   err_next = !bus.i_rx_valid && timer_expired;
            default: err_next = bus.i_rx_valid;
        endcase
    end

    // Sequencer state, timer and every registered output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            cmd_addr_reg <= '0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_addr_reg  <= '0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            err_reg      <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            wr_valid_reg <= 1'b0;
            rd_valid_reg <= 1'b0;

            // Error pulse lags its cause by one cycle; the counter saturates.
            err_reg <= err_next;
            if (err_next && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.i_rx_valid) begin
                        if (op_is_wr) begin
                            cmd_addr_reg <= bus.i_rx_data[3:0];
                            timer_reg    <= '0;
                            state_reg    <= WDATA;
                        end else if (op_is_rd) begin
                            rd_addr_reg  <= bus.i_rx_data[3:0];
                            rd_valid_reg <= 1'b1;
                            state_reg    <= READ;
                        end
                    end
                end

                WDATA: begin
                    if (bus.i_rx_valid) begin
                        // Data byte wins even on the expiry cycle.
                        wr_valid_reg <= 1'b1;
                        wr_addr_reg  <= cmd_addr_reg;
                        wr_data_reg  <= bus.i_rx_data;
                        timer_reg    <= '0;
                        state_reg    <= WRITE;
                    end else if (timer_expired) begin
                        timer_reg <= '0;
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_next;
                    end
                end

                // Write strobe is visible during this state.
                WRITE: state_reg <= IDLE;

                // Read strobe is visible during this state; data comes next cycle.
                READ: state_reg <= CAPT;

                CAPT: begin
                    tx_data_reg  <= bus.i_rd_data;
                    tx_valid_reg <= 1'b1;
                    state_reg    <= SEND;
                end

                SEND: begin
                    // Hold the response byte until the transmitter takes it.
                    if (bus.i_tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_wr_valid = wr_valid_reg;
    assign bus.o_wr_addr  = wr_addr_reg;
    assign bus.o_wr_data  = wr_data_reg;
    assign bus.o_rd_valid = rd_valid_reg;
    assign bus.o_rd_addr  = rd_addr_reg;
    assign bus.o_tx_valid = tx_valid_reg;
    assign bus.o_tx_data  = tx_data_reg;
    assign bus.o_err      = err_reg;
    assign bus.o_err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_x_uart_cmd_ctrl.sv
// Testbench for x_uart_cmd_ctrl: directed protocol steps followed by random
// command traffic, checked against a register-bank / error-count model.
module tb_x_uart_cmd_ctrl;

    localparam int c_timeout = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    x_uart_cmd_ctrl_if bus ();

    x_uart_cmd_ctrl #(
        .p_timeout (c_timeout)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Counters
    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] model_bank [16];
    int exp_errs   = 0;  // expected o_err_cnt
    int exp_pulses = 0;  // expected total o_err pulses
    int exp_wr     = 0;
    int exp_rd     = 0;

    // Observed strobe counts and the register-bank responder
    int mon_wr   = 0;
    int mon_rd   = 0;
    int mon_err  = 0;
    int mon_both = 0;
    logic [7:0] slave_bank [16];
    logic       pend      = 1'b0;
    logic [3:0] pend_addr = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle(s); acts as bus monitor and
    // register-bank responder (read data presented the cycle after the strobe).
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.o_wr_valid) begin
                mon_wr++;
                slave_bank[bus.o_wr_addr] = bus.o_wr_data;
            end
            if (bus.o_rd_valid) mon_rd++;
            if (bus.o_err) mon_err++;
            if (bus.o_wr_valid && bus.o_rd_valid) mon_both++;
            bus.i_rd_data = pend ? slave_bank[pend_addr] : 8'($urandom);
            pend      = bus.o_rd_valid;
            pend_addr = bus.o_rd_addr;
            #1;
        end
    endtask

    task automatic err_expected();
        exp_pulses++;
        if (exp_errs < 255) exp_errs++;
    endtask

    // Present one byte for one cycle; returns in the following cycle.
    task automatic send(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick(1);
        bus.i_rx_valid = 1'b0;
    endtask

    // Write: opcode, then data byte 'gap' cycles later.
    task automatic wr_cmd(input logic [3:0] a, input logic [7:0] d, input logic [1:0] ign, input int gap);
        send({2'b10, ign, a});
        chk("wr_early", bus.o_wr_valid, 1'b0);
        if (gap > 1) tick(gap - 1);
        send(d);
        chk("wr_strobe", bus.o_wr_valid, 1'b1);
        chk("wr_addr", bus.o_wr_addr, a);
        chk("wr_data", bus.o_wr_data, d);
        chk("wr_no_err", bus.o_err, 1'b0);
        chk("wr_no_rd", bus.o_rd_valid, 1'b0);
        model_bank[a] = d;
        exp_wr++;
        tick(1);
        chk("wr_one_cycle", bus.o_wr_valid, 1'b0);
        chk("wr_addr_hold", bus.o_wr_addr, a);
        chk("wr_data_hold", bus.o_wr_data, d);
    endtask

    // Read: opcode, response expected at N+3, transmitter stalls 'delay' cycles.
    task automatic rd_cmd(input logic [3:0] a, input logic [1:0] ign, input int delay);
        logic [7:0] exp_d;
        exp_d = model_bank[a];
        send({2'b01, ign, a});
        chk("rd_strobe", bus.o_rd_valid, 1'b1);
        chk("rd_addr", bus.o_rd_addr, a);
        chk("rd_no_wr", bus.o_wr_valid, 1'b0);
        exp_rd++;
        tick(1);
        chk("rd_one_cycle", bus.o_rd_valid, 1'b0);
        chk("tx_not_yet", bus.o_tx_valid, 1'b0);
        bus.i_tx_ready = (delay == 0);
        tick(1);
        chk("tx_valid", bus.o_tx_valid, 1'b1);
        chk("tx_data", bus.o_tx_data, exp_d);
        for (int i = 0; i < delay; i++) begin
            tick(1);
            chk("tx_hold_valid", bus.o_tx_valid, 1'b1);
            chk("tx_hold_data", bus.o_tx_data, exp_d);
        end
        bus.i_tx_ready = 1'b1;
        tick(1);
        chk("tx_drop", bus.o_tx_valid, 1'b0);
        bus.i_tx_ready = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        int kind;
        int snap;

        rst            = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_tx_ready = 1'b0;
        tick(3);

        // Reset state
        chk("rst_wr_valid", bus.o_wr_valid, 1'b0);
        chk("rst_wr_addr", bus.o_wr_addr, 4'h0);
        chk("rst_wr_data", bus.o_wr_data, 8'h00);
        chk("rst_rd_valid", bus.o_rd_valid, 1'b0);
        chk("rst_rd_addr", bus.o_rd_addr, 4'h0);
        chk("rst_tx_valid", bus.o_tx_valid, 1'b0);
        chk("rst_tx_data", bus.o_tx_data, 8'h00);
        chk("rst_err", bus.o_err, 1'b0);
        chk("rst_err_cnt", bus.o_err_cnt, 8'h00);
        rst = 1'b0;
        tick(2);

        // Write 0x83 then 0x5A ten cycles later
        wr_cmd(4'h3, 8'h5A, 2'b00, 10);
        chk("wr_err_cnt", bus.o_err_cnt, exp_errs);

        // Read 0x47 with ready held high (register 7 preloaded with 0xC3)
        wr_cmd(4'h7, 8'hC3, 2'b00, 1);
        rd_cmd(4'h7, 2'b00, 0);

        // Read with 20 cycles of backpressure and a stray byte mid-wait
        send(8'h47);
        chk("bp_rd_strobe", bus.o_rd_valid, 1'b1);
        exp_rd++;
        bus.i_tx_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", bus.o_tx_valid, 1'b1);
            chk("bp_data", bus.o_tx_data, 8'hC3);
            if (i == 4) begin
                bus.i_rx_data  = 8'h83;
                bus.i_rx_valid = 1'b1;
            end
            if (i == 5) begin
                bus.i_rx_valid = 1'b0;
                err_expected();
                chk("bp_err", bus.o_err, 1'b1);
                chk("bp_err_cnt", bus.o_err_cnt, exp_errs);
            end
            tick(1);
        end
        bus.i_tx_ready = 1'b1;
        chk("bp_valid_last", bus.o_tx_valid, 1'b1);
        tick(1);
        chk("bp_drop", bus.o_tx_valid, 1'b0);
        bus.i_tx_ready = 1'b0;

        // Timeout: opcode 0x81 then silence
        send(8'h81);
        for (int i = 0; i < 15; i++) begin
            chk("to_quiet", bus.o_err, 1'b0);
            tick(1);
        end
        chk("to_quiet_last", bus.o_err, 1'b0);
        tick(1);
        err_expected();
        chk("to_err", bus.o_err, 1'b1);
        chk("to_no_wr", bus.o_wr_valid, 1'b0);
        chk("to_err_cnt", bus.o_err_cnt, exp_errs);
        tick(1);
        chk("to_err_pulse", bus.o_err, 1'b0);

        // Data byte landing exactly on the expiry cycle is accepted
        wr_cmd(4'h1, 8'hE7, 2'b00, c_timeout);
        chk("to_edge_no_err", bus.o_err, 1'b0);
        chk("to_edge_err_cnt", bus.o_err_cnt, exp_errs);

        // Invalid opcodes 0x00 and 0xC0 back to back
        send(8'h00);
        err_expected();
        chk("inv0_err", bus.o_err, 1'b1);
        send(8'hC0);
        err_expected();
        chk("inv1_err", bus.o_err, 1'b1);
        chk("inv_err_cnt", bus.o_err_cnt, exp_errs);
        tick(1);
        chk("inv_err_end", bus.o_err, 1'b0);

        // 300 invalid bytes: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            v    = 8'($urandom);
            v[6] = v[7];
            send(v);
            err_expected();
            chk("sat_err", bus.o_err, 1'b1);
            chk("sat_cnt", bus.o_err_cnt, exp_errs);
        end
        tick(2);
        chk("sat_final", bus.o_err_cnt, 8'd255);

        // Reset in the middle of a write command
        send(8'h82);
        tick(2);
        rst = 1'b1;
        #1;
        chk("arst_err_cnt", bus.o_err_cnt, 8'h00);
        chk("arst_wr_addr", bus.o_wr_addr, 4'h0);
        tick(1);
        rst      = 1'b0;
        exp_errs = 0;
        tick(1);
        snap = mon_wr;
        send(8'h11);
        err_expected();
        chk("mid_rst_err", bus.o_err, 1'b1);
        chk("mid_rst_err_cnt", bus.o_err_cnt, exp_errs);
        tick(20);
        chk("mid_rst_no_wr", mon_wr - snap, 0);

        // Random traffic: fill every register, then mixed commands
        for (int a = 0; a < 16; a++) begin
            wr_cmd(4'(a), 8'($urandom), 2'($urandom), $urandom_range(1, 12));
        end
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: wr_cmd(4'($urandom), 8'($urandom), 2'($urandom), $urandom_range(1, c_timeout));
                1: rd_cmd(4'($urandom), 2'($urandom), $urandom_range(0, 6));
                2: begin
                    v    = 8'($urandom);
                    v[6] = v[7];
                    send(v);
                    err_expected();
                    chk("rnd_inv_err", bus.o_err, 1'b1);
                    chk("rnd_inv_cnt", bus.o_err_cnt, exp_errs);
                    tick(1);
                end
                default: tick($urandom_range(1, 5));
            endcase
        end

        // Totals over the whole run
        tick(3);
        chk("never_both_strobes", mon_both, 0);
        chk("total_writes", mon_wr, exp_wr);
        chk("total_reads", mon_rd, exp_rd);
        chk("total_err_pulses", mon_err, exp_pulses);
        chk("final_err_cnt", bus.o_err_cnt, exp_errs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/x_uart_cmd_ctrl.md
Name: x_uart_cmd_ctrl

Overview:
Command sequencer sitting behind the UART receiver and in front of the UART transmitter. It parses received bytes into register-write and register-read commands, drives a small register-bank strobe interface, and schedules read responses onto the TX byte handshake. It also enforces an inter-byte timeout and counts protocol errors.

Parameters:
p_timeout, 1200, clock cycles allowed between opcode byte and write-data byte before abort; timer width = $clog2(p_timeout+1)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
i_rx_valid  input  1  one-cycle strobe, received byte available
i_rx_data  input  8  received byte, valid with i_rx_valid
o_wr_valid  output  1  one-cycle register write strobe
o_wr_addr  output  4  register write address
o_wr_data  output  8  register write data
o_rd_valid  output  1  one-cycle register read strobe
o_rd_addr  output  4  register read address
i_rd_data  input  8  read data, valid the cycle after o_rd_valid
o_tx_valid  output  1  response byte valid to transmitter
o_tx_data  output  8  response byte
i_tx_ready  input  1  transmitter accepts byte when high with o_tx_valid
o_err  output  1  one-cycle protocol error pulse
o_err_cnt  output  8  saturating error count

Behaviour:
- Reset (async, i_rst high): state IDLE; all outputs 0; timer 0; o_err_cnt 0. Reset mid-command discards the command; no strobe is issued afterwards.
- Opcode format: bits[7:6] = 2'b10 write, 2'b01 read, other values invalid; bits[5:4] ignored; bits[3:0] address.
- States: IDLE, WDATA, WRITE, READ, CAPT, SEND.
- IDLE:
  - i_rx_valid with a write opcode: latch address, clear timer, go to WDATA.
  - Read opcode: latch address, go to READ.
  - Invalid opcode: o_err pulse next cycle; stay in IDLE.
- WDATA:
  - Timer increments each cycle.
  - i_rx_valid: latch data, go to WRITE.
  - Timer reaches p_timeout with no byte: o_err pulse, go to IDLE.
  - A byte arriving in the same cycle as expiry wins: it is accepted as data and no error is raised.
- WRITE: o_wr_valid high for exactly 1 cycle with latched addr/data, then IDLE. Latency: data byte strobe in cycle N gives o_wr_valid in cycle N+1.
- READ: o_rd_valid high 1 cycle with o_rd_addr, then CAPT. Opcode strobe in cycle N gives o_rd_valid in cycle N+1.
- CAPT: sample i_rd_data into the response register (cycle N+2), go to SEND.
- SEND:
  - o_tx_valid is high from cycle N+3 until the handshake (o_tx_valid & i_tx_ready).
  - o_tx_data stays stable while valid.
  - On handshake, o_tx_valid drops the next cycle and the state returns to IDLE.
  - If i_tx_ready is already high, the handshake completes in 1 cycle.
- Bytes arriving in WRITE, READ, CAPT or SEND are dropped with an o_err pulse; the current command is unaffected.
- o_wr_addr/o_wr_data/o_rd_addr hold their last values when not strobed. o_wr_valid and o_rd_valid are never high together.
- o_err is registered, 1 cycle after the causing event.
- o_err_cnt increments on each o_err pulse and saturates at 255 (no wrap).
- Timer is only active in WDATA and is cleared on entry.

Test Plan:
- Write: rx 0x83, then 0x5A ten cycles later -> o_wr_valid one cycle after the 0x5A strobe with addr 3, data 0x5A; no o_err.
- Read, ready held high: rx 0x47 at cycle N, i_rd_data=0xC3 at N+2 -> o_rd_valid at N+1 with addr 7; o_tx_valid/o_tx_data=0xC3 at N+3 for 1 cycle; back to IDLE.
- Read backpressure: as above with i_tx_ready low for 20 cycles -> o_tx_valid and 0xC3 held stable 20 cycles, dropped the cycle after ready rises; an rx byte during the wait gives an o_err pulse and o_err_cnt=1, response unchanged.
- Timeout: p_timeout=16, rx 0x81 then silence -> o_err pulse after 16 cycles, no o_wr_valid. Repeat with the data byte landing exactly on the expiry cycle -> write issued, no error.
- Invalid/saturation: rx 0x00 and 0xC0 -> two o_err pulses; send 300 invalid bytes -> o_err_cnt stops at 255.
- Reset mid-command: rx 0x82, assert i_rst, release, then rx 0x11 -> no write strobe; 0x11 is treated as an invalid opcode (o_err, count 1 after reset).
